// File: rtl/sram_array.sv
// sram_array: single-port synchronous SRAM built from an async-clear register array.
// One access per clock: write when i_write=1, otherwise read. Read-first on writes,
// one-cycle registered read data, out-of-range addresses read 0 and drop writes.
module sram_array #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Implemented depth is capped by what the address bus can reach.
    localparam int ADDR_SPAN = 2 ** ADDR_WIDTH;
    localparam int IMPL_DEPTH = (DEPTH < ADDR_SPAN) ? DEPTH : ADDR_SPAN;

    logic [DATA_WIDTH-1:0] mem_q [IMPL_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [IMPL_DEPTH];
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // Address decode over implemented words only; unmatched addresses read 0 and
    // write nothing. An X on i_write falls to the read branch, so no write occurs.
    always_comb begin
        data_d = '0;
        for (int k = 0; k < IMPL_DEPTH; k++) begin
            mem_d[k] = mem_q[k];
            if (i_addr == ADDR_WIDTH'(k)) begin
                data_d = mem_q[k];
                if (i_write) begin
                    mem_d[k] = i_data;
                end
            end
        end
    end

    // Array and output register; reset clears every word and the read data at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < IMPL_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            data_q <= '0;
        end else begin
            for (int k = 0; k < IMPL_DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_sram_array.sv
// Bench for sram_array: two instances share stimulus (default depth 16, and DEPTH=8).
// A reference model per instance predicts read-first data, pushed to a queue at drive
// time and popped when the registered output is due.
module tb_sram_array;

    localparam int AW = 4;
    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          wr = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] o16;
    logic [DW-1:0] o8;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] m16 [16];
    logic [DW-1:0] m8  [8];
    logic [DW-1:0] exp16_q [$];
    logic [DW-1:0] exp8_q  [$];
    logic [DW-1:0] vals    [8];

    sram_array #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr),
        .i_write(wr), .i_data(wdata), .o_data(o16)
    );

    sram_array #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr),
        .i_write(wr), .i_data(wdata), .o_data(o8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) m16[k] = '0;
        for (int k = 0; k < 8; k++) m8[k] = '0;
    endtask

    // One access: drive at negedge, predict, update model at posedge, compare after it.
    task automatic op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        wr = w; addr = a; wdata = d;
        exp16_q.push_back(m16[a]);
        exp8_q.push_back((a < 8) ? m8[a] : '0);
        @(posedge clk);
        if (w === 1'b1) begin
            m16[a] = d;
            if (a < 8) m8[a] = d;
        end
        #1;
        chk($sformatf("%s16_a%0d", tag, a), o16, exp16_q.pop_front());
        chk($sformatf("%s8_a%0d", tag, a), o8, exp8_q.pop_front());
    endtask

    function automatic logic [DW-1:0] pack(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[9:0]};
    endfunction

    initial begin
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] ones;
        model_clear();
        vals[0] = pack(100, 0, 0, 245);
        vals[1] = pack(1, 2, 3, 17);
        vals[2] = pack(255, 128, 7, 1023);
        vals[3] = pack(9, 90, 200, 512);
        vals[4] = pack(0, 255, 0, 1);
        vals[5] = pack(77, 66, 55, 444);
        vals[6] = pack(170, 85, 170, 341);
        vals[7] = pack(0, 0, 100, 695);
        va = pack(18, 52, 86, 120);
        vb = pack(171, 205, 239, 987);
        ones = '1;

        // reset state
        #12;
        chk("rst16", o16, '0);
        chk("rst8", o8, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // test 1: fresh array reads zero everywhere
        for (int a = 0; a < 16; a++) op(1'b0, AW'(a), '0, "t1");

        // test 2: write 0..7, read back, upper half stays zero
        for (int a = 0; a < 8; a++) op(1'b1, AW'(a), vals[a], "t2w");
        for (int a = 0; a < 8; a++) begin
            op(1'b0, AW'(a), '0, "t2r");
            chk($sformatf("t2abs_a%0d", a), o16, vals[a]);
        end
        for (int a = 8; a < 16; a++) op(1'b0, AW'(a), '0, "t2hi");

        // test 4: back-to-back reads, one-cycle lag
        op(1'b0, 4'd1, '0, "t4");
        op(1'b0, 4'd2, '0, "t4");
        op(1'b0, 4'd1, '0, "t4");
        chk("t4abs", o16, vals[1]);

        // X on write strobe must behave as a read
        op(1'bx, 4'd5, ones, "tx");
        op(1'b0, 4'd5, '0, "txr");
        chk("txabs", o16, vals[5]);

        // test 5: async reset between edges clears output immediately
        op(1'b0, 4'd7, '0, "t5pre");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5async16", o16, '0);
        chk("t5async8", o8, '0);
        wr = 1'b1; addr = 4'd5; wdata = ones;
        @(posedge clk);
        #1;
        chk("t5held16", o16, '0);
        model_clear();
        @(negedge clk);
        wr = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) op(1'b0, AW'(a), '0, "t5r");

        // test 3: read-first on consecutive writes to the same address
        op(1'b1, 4'd3, va, "t3a");
        chk("t3old0", o16, '0);
        op(1'b1, 4'd3, vb, "t3b");
        chk("t3oldA", o16, va);
        op(1'b0, 4'd3, '0, "t3r");
        chk("t3newB", o16, vb);

        // test 6: DEPTH=8 instance drops out-of-range write, reads 0
        for (int a = 0; a < 8; a++) op(1'b1, AW'(a), vals[a], "t6w");
        op(1'b1, 4'd12, 34'h3_FFFF_FFFF, "t6oob");
        op(1'b0, 4'd12, '0, "t6r");
        chk("t6oob8", o8, '0);
        chk("t6in16", o16, 34'h3_FFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            op(1'b0, AW'(a), '0, "t6keep");
            chk($sformatf("t6abs8_a%0d", a), o8, vals[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
